// File: rtl/cordic_issue_ctrl.sv
// Operand FIFO, range screen and start/clk_en sequencing for the unrolled
// cosine CORDIC core; the result is presented on a registered valid/ready port.
module cordic_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                     clock,
    input  logic                     aclr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic                     out_err,
    output logic                     core_aclr,
    output logic                     core_clk_en,
    output logic                     core_start,
    output logic [31:0]              core_dataa,
    input  logic [31:0]              core_result,
    input  logic                     core_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        OUT
    } state_t;

    state_t          state;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   tcnt;
    logic            push;
    logic            pop;
    logic            reject;
    logic [31:0]     head_abs;

    assign in_ready = fifo_count < DEPTH_C;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (fifo_count != '0) && !core_aclr;
    assign head_abs = {1'b0, mem[rd_ptr][30:0]};
    // Exponent >= 128 means |x| >= 2.0, which overflows the Q1.20 core input.
    assign reject   = head_abs[30];

    // Combinational in RUN so the core index freezes on the done cycle.
    assign core_clk_en = (state == RUN) ? !core_done : (state == LOAD);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            core_aclr <= 1'b1;
        end else begin
            core_aclr <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
            core_start <= 1'b0;
            core_dataa <= '0;
            tcnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        if (reject) begin
                            out_result <= '0;
                            out_err    <= 1'b1;
                            out_valid  <= 1'b1;
                            state      <= OUT;
                        end else begin
                            core_dataa <= head_abs;
                            core_start <= 1'b1;
                            state      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    core_start <= 1'b0;
                    tcnt       <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    if (core_done) begin
                        out_result <= core_result;
                        out_err    <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end else if (tcnt == T_LAST) begin
                        out_result <= '0;
                        out_err    <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_issue_ctrl.sv
// Bench for cordic_issue_ctrl: stand-in core, push-order scoreboard model
// and directed scenarios for latency, screening, FIFO, timeout and reset.
module tb_cordic_issue_ctrl;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        aclr  = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_err;
    logic        core_aclr;
    logic        core_clk_en;
    logic        core_start;
    logic [31:0] core_dataa;
    logic [31:0] core_result;
    logic        core_done;
    logic [2:0]  fifo_count;

    logic        hang = 1'b0;

    cordic_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(8)) dut (
        .clock       (clock),
        .aclr        (aclr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_err     (out_err),
        .core_aclr   (core_aclr),
        .core_clk_en (core_clk_en),
        .core_start  (core_start),
        .core_dataa  (core_dataa),
        .core_result (core_result),
        .core_done   (core_done),
        .fifo_count  (fifo_count)
    );

    always #5 clock = ~clock;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Stand-in core: cos(1.0) is returned one ulp off to exercise tolerance.
    function automatic logic [31:0] core_fn(input logic [31:0] x);
        if (x == 32'h3F80_0000) return 32'h3F0A_5141;
        return x ^ 32'h005A_A5C3;
    endfunction

    logic [4:0]  idx = '0;
    logic [31:0] core_op = '0;

    always @(posedge clock) begin
        if (core_aclr) begin
            idx <= '0;
        end else if (core_clk_en) begin
            if (core_start) begin
                idx     <= 5'd4;
                core_op <= core_dataa;
            end else if (idx < 5'd16) begin
                idx <= idx + 5'd4;
            end
        end
    end

    assign core_done   = !hang && (idx == 5'd16);
    assign core_result = core_fn(core_op);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic        hang;
    } op_t;

    op_t mq[$];

    // Expected {err, result} for an operation, straight from the screening rules.
    function automatic logic [32:0] model(input op_t o);
        logic [31:0] a;
        a = {1'b0, o.d[30:0]};
        if (a[30:23] >= 8'd128) return {1'b1, 32'h0};
        if (o.hang) return {1'b1, 32'h0};
        return {1'b0, core_fn(a)};
    endfunction

    logic        stall_q = 1'b0;
    logic [31:0] res_q   = '0;
    logic        err_q   = 1'b0;
    logic [32:0] expv;
    int          hs_cyc[$];

    always @(negedge clock) begin
        if (!aclr) begin
            mq.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checkb("hold_valid", out_valid, 1'b1);
                check("hold_result", out_result, res_q);
                checkb("hold_err", out_err, err_q);
            end
            if (out_valid) begin
                checkb("valid_expected", mq.size() != 0, 1'b1);
                if (mq.size() != 0) begin
                    expv = model(mq[0]);
                    check("model_result", out_result, expv[31:0]);
                    checkb("model_err", out_err, expv[32]);
                    if (out_ready) begin
                        void'(mq.pop_front());
                        hs_cyc.push_back(cyc);
                    end
                end
            end
            stall_q = out_valid && !out_ready;
            res_q   = out_result;
            err_q   = out_err;
            if (in_valid && in_ready) mq.push_back('{in_data, hang});
        end
    end

    int          n_start = 0;
    int          n_clken = 0;
    int          n_clken_run = 0;
    logic [31:0] last_dataa = '0;

    always @(negedge clock) begin
        if (aclr) begin
            if (core_start) begin
                n_start++;
                last_dataa = core_dataa;
            end
            if (core_clk_en) n_clken++;
            if (core_clk_en && !core_start) n_clken_run++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] d, output int t);
        logic done;
        done = 1'b0;
        t = -1;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            done = in_ready;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        t = cyc;
        checkb("push_accepted", done, 1'b1);
    endtask

    task automatic wait_valid(output int t);
        logic seen;
        seen = out_valid;
        for (int i = 0; i < 100 && !seen; i++) begin
            step(1);
            seen = out_valid;
        end
        t = cyc;
        checkb("valid_within_bound", seen, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkb({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_result"}, out_result, 32'h0);
        checkb({tag, "_out_err"}, out_err, 1'b0);
        checkb({tag, "_core_start"}, core_start, 1'b0);
        checkb({tag, "_core_clk_en"}, core_clk_en, 1'b0);
        check({tag, "_core_dataa"}, core_dataa, 32'h0);
        checkb({tag, "_core_aclr"}, core_aclr, 1'b1);
        check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    endtask

    logic [31:0] scr_op [3] = '{32'h3FFF_FFFF, 32'h8000_0001, 32'hC049_0FDB};
    logic [31:0] scr_da [3] = '{32'h3FFF_FFFF, 32'h0000_0001, 32'h0};
    int          scr_st [3] = '{1, 1, 0};
    logic [31:0] ff_op  [6] = '{32'h3E80_0000, 32'h3F00_0000, 32'h3F40_0000,
                                32'h3FC0_0000, 32'h0000_0000, 32'h3F80_0001};

    initial begin
        int t0, t1, s0, c0, diff, seen;
        logic [31:0] r1;

        #2 aclr = 1'b0;
        step(3);
        check_reset_outputs("reset");
        checkb("reset_in_ready", in_ready, 1'b1);
        aclr = 1'b1;
        #1 checkb("core_aclr_after_release", core_aclr, 1'b1);
        step(1);
        checkb("core_aclr_cleared", core_aclr, 1'b0);

        s0 = n_start;
        c0 = n_clken;
        push(32'h3F80_0000, t0);
        wait_valid(t1);
        check("latency_6", t1 - t0, 32'd6);
        r1   = out_result;
        diff = $signed(out_result - 32'h3F0A_5140);
        checkb("cos1_within_tol", diff >= -64 && diff <= 64, 1'b1);
        checkb("cos1_err", out_err, 1'b0);
        step(2);
        check("cos1_one_start", n_start - s0, 32'd1);
        check("cos1_clken_cycles", n_clken - c0, 32'd4);

        push(32'hBF80_0000, t0);
        wait_valid(t1);
        check("neg1_dataa", last_dataa, 32'h3F80_0000);
        check("neg1_same_result", out_result, r1);
        step(2);

        s0 = n_start;
        push(32'h4000_0000, t0);
        wait_valid(t1);
        check("two_result", out_result, 32'h0);
        checkb("two_err", out_err, 1'b1);
        step(2);
        check("two_no_start", n_start - s0, 32'd0);

        for (int i = 0; i < 3; i++) begin
            s0 = n_start;
            push(scr_op[i], t0);
            wait_valid(t1);
            step(2);
            check("screen_starts", n_start - s0, 32'(scr_st[i]));
            if (scr_st[i] == 1) check("screen_dataa", last_dataa, scr_da[i]);
        end

        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = ff_op[i];
            step(1);
        end
        in_valid = 1'b0;
        check("full_count", 32'(fifo_count), 32'd4);
        checkb("full_in_ready", in_ready, 1'b0);
        check("full_accepted", mq.size(), 32'd5);
        step(3);
        hs_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && mq.size() != 0; i++) step(1);
        check("drain_results", hs_cyc.size(), 32'd5);
        for (int i = 1; i < hs_cyc.size(); i++) begin
            check("drain_spacing_7", hs_cyc[i] - hs_cyc[i-1], 32'd7);
        end
        step(2);

        hang = 1'b1;
        c0 = n_clken_run;
        push(32'h3F80_0000, t0);
        wait_valid(t1);
        checkb("timeout_err", out_err, 1'b1);
        check("timeout_result", out_result, 32'h0);
        check("timeout_latency", t1 - t0, 32'd10);
        check("timeout_run_clken", n_clken_run - c0, 32'd8);
        step(1);
        hang = 1'b0;
        step(1);
        push(32'h3E00_0000, t0);
        wait_valid(t1);
        checkb("recover_err", out_err, 1'b0);
        check("recover_result", out_result, 32'h3E5A_A5C3);
        step(2);

        push(32'h3F80_0000, t0);
        step(3);
        checkb("mid_run_clk_en", core_clk_en, 1'b1);
        aclr = 1'b0;
        #1 check_reset_outputs("midreset");
        step(2);
        aclr = 1'b1;
        #1 checkb("mid_core_aclr_held", core_aclr, 1'b1);
        step(1);
        checkb("mid_core_aclr_low", core_aclr, 1'b0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            step(1);
        end
        check("no_stale_valid", seen, 32'd0);

        push(32'h3F80_0000, t0);
        wait_valid(t1);
        check("post_reset_result", out_result, r1);
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule
